// File: rtl/muxer_pkg.sv
// muxer_pkg -- shared definitions for the muxer_scan block.
//   state_t : controller states (IDLE, SCAN, DONE)
//   DEF_N   : default number of input channels
//   DEF_W   : default data width per channel
package muxer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N = 16;
  localparam int DEF_W = 1;

endpackage

// File: rtl/muxer_next_idx.sv
// muxer_next_idx -- combinational search for the next enabled channel.
//   cur   : current channel index
//   first : 1 = search from channel 0 inclusive (scan start),
//           0 = search strictly above cur
//   mask  : per-channel enable
//   nxt   : lowest enabled channel satisfying the search (0 when none)
//   none  : no enabled channel left
module muxer_next_idx
  import muxer_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int SW = $clog2(N)
) (
  input  logic [SW-1:0] cur,
  input  logic          first,
  input  logic [N-1:0]  mask,
  output logic [SW-1:0] nxt,
  output logic          none
);

  // cand[k]: channel k is enabled and lies inside the search window
  logic [N-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      if (gi == 0) begin : g_zero
        // channel 0 can never be "above" the current index
        assign cand[gi] = mask[gi] & first;
      end else begin : g_rest
        assign cand[gi] = mask[gi] & (first | (cur < SW'(gi)));
      end
    end
  endgenerate

  // descending walk so the lowest candidate wins
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[k]) begin
        nxt  = SW'(k);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/muxer_scan.sv
// muxer_scan -- N-channel registered multiplexer with manual select and
// an automatic ascending scan of all (or all enabled) channels.
//
// Optional feature: define MUXER_SCAN_MASK_EN to add the en_mask input;
// a scan then visits only channels whose mask bit was set at start.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   in       : N packed channels, channel k at in[k*W +: W]
//   sel      : manual channel select
//   mode     : 0 = manual, 1 = scan (looked at only in IDLE)
//   start    : scan request (looked at only in IDLE with mode = 1)
//   en_mask  : per-channel scan enable (MUXER_SCAN_MASK_EN only)
//   q        : registered selected data
//   q_sel    : channel index shown on q
//   q_valid  : q/q_sel were sampled on the previous edge
//   busy     : scan in progress
//   done     : one-cycle pulse following the final scan sample
module muxer_scan
  import muxer_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0] sel,
  input  logic          mode,
  input  logic          start,
`ifdef MUXER_SCAN_MASK_EN
  input  logic [N-1:0]  en_mask,
`endif
  output logic [W-1:0]  q,
  output logic [SW-1:0] q_sel,
  output logic          q_valid,
  output logic          busy,
  output logic          done
);

  state_t        state_reg, state_next;
  logic [SW-1:0] idx_reg, idx_next;
  logic [W-1:0]  q_reg, q_next;
  logic [SW-1:0] q_sel_reg, q_sel_next;
  logic          q_valid_reg, q_valid_next;
  logic          done_reg, done_next;

  // mask_live feeds the first-channel search at start; mask_held is the
  // copy used for the rest of the scan so mid-scan mask changes are ignored
  logic [N-1:0]  mask_live, mask_held;

`ifdef MUXER_SCAN_MASK_EN
  logic [N-1:0]  mask_reg, mask_next;
  assign mask_live = en_mask;
  assign mask_held = mask_reg;
`else
  assign mask_live = '1;
  assign mask_held = '1;
`endif

  logic          in_idle;
  logic [SW-1:0] nidx;
  logic          nidx_none;

  assign in_idle = (state_reg == IDLE);

  muxer_next_idx #(
    .N (N)
  ) u_next_idx (
    .cur   (idx_reg),
    .first (in_idle),
    .mask  (in_idle ? mask_live : mask_held),
    .nxt   (nidx),
    .none  (nidx_none)
  );

  // sel may exceed N-1 when N is not a power of two
  logic          sel_ok;
  logic [W-1:0]  sel_data, scan_data;

  assign sel_ok    = (int'(sel) < N);
  assign sel_data  = in[int'(sel) * W +: W];
  assign scan_data = in[int'(idx_reg) * W +: W];

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    q_next       = q_reg;
    q_sel_next   = q_sel_reg;
    q_valid_next = 1'b0;
    done_next    = 1'b0;
`ifdef MUXER_SCAN_MASK_EN
    mask_next    = mask_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!mode) begin
          q_sel_next = sel;
          if (sel_ok) begin
            q_next       = sel_data;
            q_valid_next = 1'b1;
          end else begin
            q_next = '0;
          end
        end else if (start) begin
          idx_next = nidx;
`ifdef MUXER_SCAN_MASK_EN
          mask_next = en_mask;
`endif
          // nothing enabled: skip straight to the done pulse
          state_next = nidx_none ? DONE : SCAN;
        end
      end
      SCAN: begin
        q_next       = scan_data;
        q_sel_next   = idx_reg;
        q_valid_next = 1'b1;
        if (nidx_none) begin
          state_next = DONE;  // idx stays on the last channel, no wrap
        end else begin
          idx_next = nidx;
        end
      end
      DONE: begin
        // done is registered, so it shows in the cycle after DONE,
        // i.e. right after the final valid sample has been presented
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      q_reg       <= '0;
      q_sel_reg   <= '0;
      q_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
`ifdef MUXER_SCAN_MASK_EN
      mask_reg    <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      q_reg       <= q_next;
      q_sel_reg   <= q_sel_next;
      q_valid_reg <= q_valid_next;
      done_reg    <= done_next;
`ifdef MUXER_SCAN_MASK_EN
      mask_reg    <= mask_next;
`endif
    end
  end

  assign q       = q_reg;
  assign q_sel   = q_sel_reg;
  assign q_valid = q_valid_reg;
  assign busy    = (state_reg == SCAN);
  assign done    = done_reg;

endmodule

// File: tb/tb_muxer_scan.sv
// tb_muxer_scan -- drives two muxer_scan instances (N=16/W=4 and N=10/W=3)
// from shared control inputs. A reference model turns each edge's inputs
// into expected output tokens; a monitor on the falling edge compares.
module tb_muxer_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        mode  = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  sel   = '0;
  logic [63:0] in16  = '0;
  logic [29:0] in10  = '0;
  logic [15:0] mask16 = '1;
  logic [9:0]  mask10 = '1;

  logic [3:0] q16, q_sel16;
  logic       q_valid16, busy16, done16;
  logic [2:0] q10;
  logic [3:0] q_sel10;
  logic       q_valid10, busy10, done10;

  muxer_scan #(.N(16), .W(4)) u16 (
    .clk(clk), .rst(rst), .in(in16), .sel(sel), .mode(mode), .start(start),
`ifdef MUXER_SCAN_MASK_EN
    .en_mask(mask16),
`endif
    .q(q16), .q_sel(q_sel16), .q_valid(q_valid16), .busy(busy16), .done(done16)
  );

  muxer_scan #(.N(10), .W(3)) u10 (
    .clk(clk), .rst(rst), .in(in10), .sel(sel), .mode(mode), .start(start),
`ifdef MUXER_SCAN_MASK_EN
    .en_mask(mask10),
`endif
    .q(q10), .q_sel(q_sel10), .q_valid(q_valid10), .busy(busy10), .done(done10)
  );

  // mask the model sees: all channels when the mask feature is absent
  logic [15:0] eff16;
  logic [9:0]  eff10;
`ifdef MUXER_SCAN_MASK_EN
  assign eff16 = mask16;
  assign eff10 = mask10;
`else
  assign eff16 = '1;
  assign eff10 = '1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // ---------------- reference model ----------------
  // expected output tokens: 0 = valid sample, 1 = done pulse
  bit exp0[$];
  bit exp1[$];
  int lst[2][64];           // channels still to be visited by the scan
  int lst_len[2], lst_pos[2];
  bit m_active[2], m_done_due[2], m_busy[2];
  int m_q[2], m_qsel[2];

  function automatic int field(input logic [63:0] v, input int ch, input int w);
    logic [63:0] t;
    t = (v >> (ch * w)) & ((64'd1 << w) - 64'd1);
    return int'(t);
  endfunction

  task automatic push_tok(input int d, input bit t);
    if (d == 0) exp0.push_back(t);
    else        exp1.push_back(t);
  endtask

  task automatic model_edge(input int d, input int n, input int w,
                            input logic [63:0] v, input logic [63:0] m);
    int ch;
    if (rst) begin
      m_active[d] = 0; m_done_due[d] = 0; m_busy[d] = 0;
      m_q[d] = 0; m_qsel[d] = 0; lst_len[d] = 0; lst_pos[d] = 0;
    end else if (m_active[d]) begin
      ch = lst[d][lst_pos[d]];
      lst_pos[d] = lst_pos[d] + 1;
      m_q[d] = field(v, ch, w);
      m_qsel[d] = ch;
      push_tok(d, 1'b0);
      if (lst_pos[d] == lst_len[d]) begin
        m_active[d] = 0;
        m_done_due[d] = 1;
      end
      m_busy[d] = m_active[d];
    end else if (m_done_due[d]) begin
      push_tok(d, 1'b1);
      m_done_due[d] = 0;
      m_busy[d] = 0;
    end else if (!mode) begin
      m_qsel[d] = int'(sel);
      if (int'(sel) < n) begin
        m_q[d] = field(v, int'(sel), w);
        push_tok(d, 1'b0);
      end else begin
        m_q[d] = 0;
      end
    end else if (start) begin
      lst_len[d] = 0;
      lst_pos[d] = 0;
      for (int k = 0; k < n; k++) begin
        if (m[k]) begin
          lst[d][lst_len[d]] = k;
          lst_len[d] = lst_len[d] + 1;
        end
      end
      if (lst_len[d] == 0) m_done_due[d] = 1;
      else                 m_active[d] = 1;
      m_busy[d] = m_active[d];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge(0, 16, 4, in16, {48'b0, eff16});
      model_edge(1, 10, 3, {34'b0, in10}, {54'b0, eff10});
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int d, input int q, input int qsel,
                     input bit qv, input bit bz, input bit dn);
    bit have, t;
    string p;
    p = (d == 0) ? "n16" : "n10";
    have = 0;
    t = 0;
    if (d == 0 && exp0.size() > 0) begin t = exp0.pop_front(); have = 1; end
    if (d == 1 && exp1.size() > 0) begin t = exp1.pop_front(); have = 1; end
    check({p, " q_valid"}, int'(qv), int'(have && !t));
    check({p, " done"},    int'(dn), int'(have && t));
    check({p, " q"},       q,        m_q[d]);
    check({p, " q_sel"},   qsel,     m_qsel[d]);
    check({p, " busy"},    int'(bz), int'(m_busy[d]));
    if (qv || dn)
      $display("n%0d: q=%0d q_sel=%0d valid=%0b done=%0b busy=%0b",
               (d == 0) ? 16 : 10, q, qsel, qv, dn, bz);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon(0, int'(q16), int'(q_sel16), q_valid16, busy16, done16);
        mon(1, int'(q10), int'(q_sel10), q_valid10, busy10, done10);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int nb16, nb10, nv16, nv10, nd16, nd10;

  initial begin
    rst = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    check("reset n16 outputs", int'({q16, q_sel16, q_valid16, busy16, done16}), 0);
    check("reset n10 outputs", int'({q10, q_sel10, q_valid10, busy10, done10}), 0);
    rst = 1'b0;

    // manual select of channel 5, then the complementary pattern
    mode = 1'b0;
    sel  = 4'd5;
    in16 = 64'h0000_0000_00F0_0000;
    step();
    check("manual ch5 q", int'(q16), 15);
    check("manual ch5 q_sel", int'(q_sel16), 5);
    check("manual ch5 valid", int'(q_valid16), 1);
    in16 = ~64'h0000_0000_00F0_0000;
    step();
    check("manual ch5 inverted q", int'(q16), 0);

    // random manual traffic
    repeat (40) begin
      sel  = 4'($urandom_range(0, 15));
      in16 = {$urandom, $urandom};
      in10 = 30'($urandom);
      step();
    end

    // out-of-range select on the 10-channel instance
    sel = 4'd12;
    in10 = '1;
    step();
    check("n10 sel12 q", int'(q10), 0);
    check("n10 sel12 valid", int'(q_valid10), 0);
    check("n10 sel12 q_sel", int'(q_sel10), 12);

    // scan mode idle: outputs hold, valid low
    mode = 1'b1;
    start = 1'b0;
    repeat (3) step();

    // full scan with in[k] = k; start/mode/sel noise during the scan
    for (int k = 0; k < 16; k++) in16[k*4 +: 4] = 4'(k);
    for (int k = 0; k < 10; k++) in10[k*3 +: 3] = 3'(k);
    mask16 = '1;
    mask10 = '1;
    start = 1'b1;
    step();
    start = 1'b0;
    nb16 = int'(busy16); nb10 = int'(busy10);
    nv16 = 0; nv10 = 0; nd16 = 0; nd10 = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 9) begin
        start = 1'($urandom);
        mode  = 1'($urandom);
        sel   = 4'($urandom);
      end else begin
        mode  = 1'b1;
        start = 1'b0;
      end
      step();
      nb16 += int'(busy16);    nb10 += int'(busy10);
      nv16 += int'(q_valid16); nv10 += int'(q_valid10);
      nd16 += int'(done16);    nd10 += int'(done10);
    end
    check("full scan n16 busy cycles", nb16, 16);
    check("full scan n10 busy cycles", nb10, 10);
    check("full scan n16 samples", nv16, 16);
    check("full scan n10 samples", nv10, 10);
    check("full scan n16 done pulses", nd16, 1);
    check("full scan n10 done pulses", nd10, 1);

    // reset on the fifth scan sample, then rescan from channel 0
    mode = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    check("abort n16 outputs", int'({q16, q_sel16, q_valid16, busy16, done16}), 0);
    rst = 1'b0;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("rescan first q_sel", int'(q_sel16), 0);
    check("rescan first valid", int'(q_valid16), 1);
    repeat (20) step();

    // randomised scans with live-changing inputs and masks
    for (int it = 0; it < 8; it++) begin
      mask16 = (it == 0) ? 16'h8421 : (it == 1) ? 16'h0000 : 16'($urandom);
      mask10 = (it == 0) ? 10'h221  : (it == 1) ? 10'h000  : 10'($urandom);
      mode  = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 22; c++) begin
        in16   = {$urandom, $urandom};
        in10   = 30'($urandom);
        mask16 = 16'($urandom);
        mask10 = 10'($urandom);
        if (c <= 8) begin
          start = 1'($urandom);
          mode  = 1'($urandom);
          sel   = 4'($urandom);
        end else begin
          mode  = 1'b1;
          start = 1'b0;
        end
        step();
      end
    end

    mode  = 1'b1;
    start = 1'b0;
    repeat (30) step();
    check("n16 tokens left", exp0.size(), 0);
    check("n10 tokens left", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
